// File: rtl/bp_fe_queue_rolly_fifo_pkg.sv
// rtl/bp_fe_queue_rolly_fifo_pkg.sv - shared types and helpers for the rolly fe_queue FIFO
package bp_fe_queue_rolly_fifo_pkg;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  function automatic int ptr_width(input int els);
    return $clog2(els) + 1;
  endfunction

  typedef struct packed {
    logic enq;
    logic yumi;
    logic deq;
    logic roll;
    logic clr;
  } fe_queue_ops_s;

endpackage

// File: rtl/bp_fe_queue_rolly_fifo_ptr.sv
// rtl/bp_fe_queue_rolly_fifo_ptr.sv - wrap-bit pointer counter with load and increment
module bp_fe_queue_rolly_fifo_ptr
  import bp_fe_queue_rolly_fifo_pkg::*;
#(
  parameter int ptr_width_p = ptr_width(8)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   inc_i,
  input  logic                   set_i,
  input  logic [ptr_width_p-1:0] val_i,
  output logic [ptr_width_p-1:0] ptr_o
);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ptr_o <= '0;
    end else if (set_i) begin
      ptr_o <= val_i;
    end else if (inc_i) begin
      ptr_o <= ptr_o + ptr_width_p'(1);
    end
  end

endmodule

// File: rtl/bp_fe_queue_rolly_fifo.sv
// rtl/bp_fe_queue_rolly_fifo.sv - FE-to-BE replayable FIFO (optional FE_QUEUE_BYPASS_EN)
module bp_fe_queue_rolly_fifo
  import bp_fe_queue_rolly_fifo_pkg::*;
#(
  parameter int width_p = 64,
  parameter int els_p   = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] fe_queue_i,
  input  logic               fe_queue_v_i,
  output logic               fe_queue_ready_o,
  output logic [width_p-1:0] fe_queue_o,
  output logic               fe_queue_v_o,
  input  logic               fe_queue_yumi_i,
  input  logic               fe_queue_deq_i,
  input  logic               fe_queue_roll_i,
  input  logic               fe_queue_clr_i
);

  localparam int ptr_w_lp = ptr_width(els_p);
  localparam int idx_w_lp = ptr_w_lp - 1;

  logic [ptr_w_lp-1:0] wptr, rptr, cptr, cptr_n, rptr_load;
  logic                full, empty, bypass_v;
  fe_queue_ops_s       ops;

  logic [width_p-1:0] mem [els_p];

  assign full  = (wptr - cptr) == ptr_w_lp'(els_p);
  assign empty = (rptr == wptr);

`ifdef FE_QUEUE_BYPASS_EN
  // Bypass only when nothing older is pending and the write can actually land.
  assign bypass_v = empty & ~full & ~fe_queue_clr_i & ~fe_queue_roll_i & fe_queue_v_i;
`else
  assign bypass_v = 1'b0;
`endif

  assign ops.clr  = fe_queue_clr_i;
  assign ops.roll = fe_queue_roll_i & ~fe_queue_clr_i;
  assign ops.enq  = fe_queue_v_i & ~full & ~fe_queue_clr_i;
  assign ops.deq  = fe_queue_deq_i & ~fe_queue_clr_i;
  assign ops.yumi = fe_queue_yumi_i & ~fe_queue_clr_i & ~fe_queue_roll_i;

  // Roll rewinds to the commit point after this cycle's deq has been applied.
  assign cptr_n    = cptr + ptr_w_lp'(ops.deq);
  assign rptr_load = ops.clr ? wptr : cptr_n;

  bp_fe_queue_rolly_fifo_ptr #(.ptr_width_p(ptr_w_lp)) wptr_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .inc_i   (ops.enq),
    .set_i   (1'b0),
    .val_i   ('0),
    .ptr_o   (wptr)
  );

  bp_fe_queue_rolly_fifo_ptr #(.ptr_width_p(ptr_w_lp)) rptr_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .inc_i   (ops.yumi),
    .set_i   (ops.clr | ops.roll),
    .val_i   (rptr_load),
    .ptr_o   (rptr)
  );

  bp_fe_queue_rolly_fifo_ptr #(.ptr_width_p(ptr_w_lp)) cptr_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .inc_i   (ops.deq),
    .set_i   (ops.clr),
    .val_i   (wptr),
    .ptr_o   (cptr)
  );

  always_ff @(posedge clk_i) begin
    if (ops.enq) begin
      mem[wptr[idx_w_lp-1:0]] <= fe_queue_i;
    end
  end

  assign fe_queue_ready_o = ~full;
  assign fe_queue_v_o     = ~empty | bypass_v;
  assign fe_queue_o       = bypass_v ? fe_queue_i : mem[rptr[idx_w_lp-1:0]];

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(fe_queue_yumi_i && !fe_queue_v_o))
        else $error("fe_queue: yumi while no valid output");
      assert (!(ops.deq && (cptr == rptr)))
        else $error("fe_queue: deq with nothing read-but-uncommitted");
      assert (!(ops.enq && full))
        else $error("fe_queue: enqueue into full queue");
    end
  end
`endif

endmodule
